// File: rtl/register_bank.sv
// MIPS general-purpose register file: write-back port, two bypassed decode
// read ports and a valid/ready debug dump streamer.
module register_bank #(
    parameter int DATA_SIZE = 32,
    parameter int REG_SIZE  = 5,
    parameter int REG_COUNT = 32
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_reg_write,
    input  logic [REG_SIZE-1:0]  i_selected_reg,
    input  logic [DATA_SIZE-1:0] i_selected_data,
    input  logic [REG_SIZE-1:0]  i_read_reg_a,
    input  logic [REG_SIZE-1:0]  i_read_reg_b,
    output logic [DATA_SIZE-1:0] o_data_a,
    output logic [DATA_SIZE-1:0] o_data_b,
    input  logic                 i_dump_start,
    input  logic                 i_dump_ready,
    output logic                 o_dump_valid,
    output logic [REG_SIZE-1:0]  o_dump_index,
    output logic [DATA_SIZE-1:0] o_dump_data,
    output logic                 o_dump_done
);

    localparam logic [REG_SIZE-1:0] LAST_IDX = REG_SIZE'(REG_COUNT - 1);

    typedef enum logic [1:0] {IDLE, DUMP, DONE} state_t;

    state_t               state;
    logic [DATA_SIZE-1:0] regs [REG_COUNT];
    logic [REG_SIZE-1:0]  next_index;
    logic [DATA_SIZE-1:0] next_data;
    logic                 transfer;

    // Register 0 is hardwired to zero; otherwise an in-flight write wins over storage.
    function automatic logic [DATA_SIZE-1:0] bypass_read(
        input logic [REG_SIZE-1:0]  addr,
        input logic [DATA_SIZE-1:0] stored,
        input logic                 wr,
        input logic [REG_SIZE-1:0]  wr_reg,
        input logic [DATA_SIZE-1:0] wr_data
    );
        if (addr == '0)
            return '0;
        else if (wr && (wr_reg == addr))
            return wr_data;
        else
            return stored;
    endfunction

    always_comb begin
        o_data_a   = bypass_read(i_read_reg_a, regs[i_read_reg_a],
                                 i_reg_write, i_selected_reg, i_selected_data);
        o_data_b   = bypass_read(i_read_reg_b, regs[i_read_reg_b],
                                 i_reg_write, i_selected_reg, i_selected_data);
        next_index = o_dump_index + 1'b1;
        next_data  = bypass_read(next_index, regs[next_index],
                                 i_reg_write, i_selected_reg, i_selected_data);
        transfer   = o_dump_valid && i_dump_ready;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < REG_COUNT; i++)
                regs[i] <= '0;
        end else if (i_reg_write && (i_selected_reg != '0)) begin
            regs[i_selected_reg] <= i_selected_data;
        end
    end

    // Dump word and index are captured registers, so a stalled word stays a snapshot.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state        <= IDLE;
            o_dump_valid <= 1'b0;
            o_dump_index <= '0;
            o_dump_data  <= '0;
            o_dump_done  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    o_dump_done <= 1'b0;
                    if (i_dump_start) begin
                        state        <= DUMP;
                        o_dump_valid <= 1'b1;
                        o_dump_index <= '0;
                        o_dump_data  <= '0;
                    end
                end
                DUMP: begin
                    if (transfer) begin
                        if (o_dump_index == LAST_IDX) begin
                            state        <= DONE;
                            o_dump_valid <= 1'b0;
                            o_dump_done  <= 1'b1;
                        end else begin
                            o_dump_index <= next_index;
                            o_dump_data  <= next_data;
                        end
                    end
                end
                DONE: begin
                    state       <= IDLE;
                    o_dump_done <= 1'b0;
                end
                default: begin
                    state        <= IDLE;
                    o_dump_valid <= 1'b0;
                    o_dump_done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_register_bank.sv
// Directed bench for register_bank: writes, bypass, full dump, backpressure,
// write-on-transfer and reset during a dump.
module tb_register_bank;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        reg_write;
    logic [4:0]  selected_reg;
    logic [31:0] selected_data;
    logic [4:0]  read_reg_a;
    logic [4:0]  read_reg_b;
    logic [31:0] data_a;
    logic [31:0] data_b;
    logic        dump_start;
    logic        dump_ready;
    logic        dump_valid;
    logic [4:0]  dump_index;
    logic [31:0] dump_data;
    logic        dump_done;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    register_bank #(.DATA_SIZE(32), .REG_SIZE(5), .REG_COUNT(32)) dut (
        .i_clk           (clk),
        .i_rst_n         (rst_n),
        .i_reg_write     (reg_write),
        .i_selected_reg  (selected_reg),
        .i_selected_data (selected_data),
        .i_read_reg_a    (read_reg_a),
        .i_read_reg_b    (read_reg_b),
        .o_data_a        (data_a),
        .o_data_b        (data_b),
        .i_dump_start    (dump_start),
        .i_dump_ready    (dump_ready),
        .o_dump_valid    (dump_valid),
        .o_dump_index    (dump_index),
        .o_dump_data     (dump_data),
        .o_dump_done     (dump_done)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge; inputs are driven from here.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic write_reg(input logic [4:0] r, input logic [31:0] d);
        reg_write     = 1'b1;
        selected_reg  = r;
        selected_data = d;
        step();
        reg_write     = 1'b0;
    endtask

    initial begin
        int words;
        int dones;
        int seq_err;

        rst_n = 1'b0; reg_write = 1'b0; selected_reg = '0; selected_data = '0;
        read_reg_a = 5'd3; read_reg_b = 5'd0; dump_start = 1'b0; dump_ready = 1'b0;
        step(); step();
        #1;
        chk("rst_valid", {31'b0, dump_valid}, 32'd0);
        chk("rst_done",  {31'b0, dump_done},  32'd0);
        chk("rst_index", {27'b0, dump_index}, 32'd0);
        chk("rst_data",  dump_data, 32'd0);
        chk("rst_read_a", data_a, 32'd0);
        rst_n = 1'b1;
        step();

        // Plain write then read, including discarded write to r0.
        write_reg(5'd5, 32'hDEADBEEF);
        read_reg_b = 5'd0;
        reg_write = 1'b1; selected_reg = 5'd0; selected_data = 32'h1234;
        #1;
        chk("r0_bypass_blocked", data_b, 32'd0);
        step();
        reg_write = 1'b0;
        read_reg_a = 5'd5; read_reg_b = 5'd0;
        #1;
        chk("read_r5", data_a, 32'hDEADBEEF);
        chk("read_r0", data_b, 32'd0);

        // Same-cycle bypass; stored value stays old until the edge.
        read_reg_a = 5'd7; read_reg_b = 5'd7;
        reg_write = 1'b0; selected_reg = 5'd7; selected_data = 32'hA5A5A5A5;
        #1;
        chk("r7_old", data_a, 32'd0);
        reg_write = 1'b1;
        #1;
        chk("bypass_a", data_a, 32'hA5A5A5A5);
        chk("bypass_b", data_b, 32'hA5A5A5A5);
        step();
        reg_write = 1'b0;
        #1;
        chk("r7_stored", data_a, 32'hA5A5A5A5);

        // Fill rN = N*0x11 and dump with ready held high.
        for (int n = 1; n < 32; n++)
            write_reg(5'(n), 32'(n) * 32'h11);
        dump_ready = 1'b1;
        dump_start = 1'b1;
        step();
        dump_start = 1'b0;
        for (int k = 0; k < 32; k++) begin
            chk("dump1_valid", {31'b0, dump_valid}, 32'd1);
            chk("dump1_index", {27'b0, dump_index}, 32'(k));
            chk("dump1_data",  dump_data, 32'(k) * 32'h11);
            chk("dump1_nodone", {31'b0, dump_done}, 32'd0);
            step();
        end
        chk("dump1_done",    {31'b0, dump_done},  32'd1);
        chk("dump1_valid_lo", {31'b0, dump_valid}, 32'd0);
        step();
        chk("dump1_done_pulse", {31'b0, dump_done}, 32'd0);

        // Backpressure at index 4 while r4 is overwritten.
        dump_start = 1'b1;
        step();
        dump_start = 1'b0;
        for (int k = 0; k < 4; k++) step();
        chk("bp_index_pre", {27'b0, dump_index}, 32'd4);
        dump_ready = 1'b0;
        reg_write = 1'b1; selected_reg = 5'd4; selected_data = 32'hFFFFFFFF;
        for (int k = 0; k < 3; k++) begin
            chk("bp_hold_valid", {31'b0, dump_valid}, 32'd1);
            chk("bp_hold_index", {27'b0, dump_index}, 32'd4);
            chk("bp_hold_data",  dump_data, 32'h44);
            step();
        end
        reg_write = 1'b0;
        dump_ready = 1'b1;
        chk("bp_last_data", dump_data, 32'h44);
        step();
        chk("bp_resume_index", {27'b0, dump_index}, 32'd5);
        chk("bp_resume_data",  dump_data, 32'h55);

        // Write to the next register on the transfer edge at index 9.
        for (int k = 0; k < 4; k++) step();
        chk("wt_index9", {27'b0, dump_index}, 32'd9);
        reg_write = 1'b1; selected_reg = 5'd10; selected_data = 32'hCAFEF00D;
        step();
        reg_write = 1'b0;
        chk("wt_index10", {27'b0, dump_index}, 32'd10);
        chk("wt_data10",  dump_data, 32'hCAFEF00D);

        // Reset in the middle of the dump.
        step(); step();
        chk("rst_mid_index12", {27'b0, dump_index}, 32'd12);
        rst_n = 1'b0;
        read_reg_a = 5'd10; read_reg_b = 5'd4;
        #1;
        chk("rst_mid_valid", {31'b0, dump_valid}, 32'd0);
        chk("rst_mid_index", {27'b0, dump_index}, 32'd0);
        chk("rst_mid_data",  dump_data, 32'd0);
        chk("rst_mid_r10",   data_a, 32'd0);
        chk("rst_mid_r4",    data_b, 32'd0);
        step();
        rst_n = 1'b1;
        dones = 0;
        for (int k = 0; k < 3; k++) begin
            if (dump_done) dones++;
            step();
        end
        chk("rst_mid_no_done", 32'(dones), 32'd0);

        // Restart; hold start high throughout to show it is ignored mid-dump.
        dump_start = 1'b1;
        step();
        chk("restart_valid", {31'b0, dump_valid}, 32'd1);
        chk("restart_index", {27'b0, dump_index}, 32'd0);
        words = 0; dones = 0; seq_err = 0;
        for (int c = 0; c < 40 && dones == 0; c++) begin
            if (dump_valid) begin
                if (dump_index != 5'(words) || dump_data != 32'd0) seq_err++;
                words++;
            end
            if (dump_done) begin
                dones++;
                dump_start = 1'b0;
            end
            step();
        end
        dump_start = 1'b0;
        chk("restart_words",   32'(words), 32'd32);
        chk("restart_seq",     32'(seq_err), 32'd0);
        chk("restart_done",    32'(dones), 32'd1);
        chk("restart_idle",    {31'b0, dump_valid}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
